register_file: RTL

REGISTER_FILE -- requirements
Module: register_file

---
 rtl/register_file.sv | 73 +++++++
 1 files changed

// File: rtl/register_file.sv
// register_file: renaming register file with busy/tag scoreboard; `REGFILE_COMMIT_BYPASS_EN adds same-cycle commit forwarding
module register_file #(
   parameter int ROBSIZE = 16,
   parameter int XLEN    = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            rdy,
   input  logic            rob_flush,
   input  logic            new_ins_flag,
   input  logic [31:0]     new_ins,
   input  logic [3:0]      rename,
   input  logic [4:0]      rename_reg,
   input  logic            commit_flag,
   input  logic [3:0]      commit_rename,
   input  logic [4:0]      commit_dest,
   input  logic [XLEN-1:0] commit_value,
   input  logic [4:0]      rs1_idx,
   input  logic [4:0]      rs2_idx,
   output logic [XLEN-1:0] rs1_value,
   output logic [XLEN-1:0] rs2_value,
   output logic            rs1_busy,
   output logic            rs2_busy,
   output logic [3:0]      rs1_tag,
   output logic [3:0]      rs2_tag
);
   logic [XLEN-1:0]    value_q [32];
   logic [3:0]         tag_q   [32];
   logic [31:0]        busy_q;
   logic [ROBSIZE-1:0] wen_tbl;
   logic               wen_new, commit_hit, byp1, byp2, unused_ins;
   assign unused_ins = ^new_ins[31:7];
   // branches and stores produce no register result
   assign wen_new    = new_ins[6:0] != 7'b1100011 && new_ins[6:0] != 7'b0100011;
   assign commit_hit = rdy && commit_flag && wen_tbl[commit_rename] && commit_dest != 5'd0;
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 32; i++) begin
            value_q[i] <= '0;
            tag_q[i]   <= '0;
         end
         busy_q  <= '0;
         wen_tbl <= '0;
      end else if (rdy) begin
         if (commit_hit) value_q[commit_dest] <= commit_value;
         if (rob_flush) busy_q <= '0;
         else begin
            if (commit_hit && tag_q[commit_dest] == commit_rename) busy_q[commit_dest] <= 1'b0;
            if (new_ins_flag) wen_tbl[rename] <= wen_new;
            // placed after the commit clear so a same-cycle rename wins
            if (new_ins_flag && wen_new && rename_reg != 5'd0) begin
               busy_q[rename_reg] <= 1'b1;
               tag_q[rename_reg]  <= rename;
            end
         end
      end
   end
`ifdef REGFILE_COMMIT_BYPASS_EN
   assign byp1 = commit_hit && busy_q[rs1_idx] && tag_q[rs1_idx] == commit_rename;
   assign byp2 = commit_hit && busy_q[rs2_idx] && tag_q[rs2_idx] == commit_rename;
`else
   assign byp1 = 1'b0;
   assign byp2 = 1'b0;
`endif
   always_comb begin
      rs1_value = rs1_idx == 5'd0 ? '0 : byp1 ? commit_value : value_q[rs1_idx];
      rs2_value = rs2_idx == 5'd0 ? '0 : byp2 ? commit_value : value_q[rs2_idx];
      rs1_busy  = busy_q[rs1_idx] && !byp1 && rs1_idx != 5'd0;
      rs2_busy  = busy_q[rs2_idx] && !byp2 && rs2_idx != 5'd0;
      rs1_tag   = tag_q[rs1_idx];
      rs2_tag   = tag_q[rs2_idx];
   end
endmodule
